uart_echo_fifo: RTL and testbench
=================================

Name: uart_echo_fifo

Overview:
- Buffered echo stage between the UART receiver (RX_READY/OUT/CLEAR handshake) and the UART transmitter (LOAD/IN/TX_BUSY handshake).
- Drains received words into a FIFO as soon as they arrive, so back-to-back RX words are not lost while TX is busy.
- Replays the words in order to the transmitter.
- Replaces the single-register echo control in the UART test top level.

Parameters:
DATA_W, 16, word width; matches the receiver OUT and transmitter IN buses
DEPTH, 16, FIFO entries; power of two, 2..256
LOAD_TIMEOUT, 1024, cycles TX_LOAD may wait for TX_BUSY before the word is abandoned

Ports:
CLK_100MHz  in  1  system clock, all logic on rising edge
RST_N  in  1  asynchronous active-low reset
RX_DATA  in  DATA_W  received word from receiver
RX_READY  in  1  receiver holds a valid word
RX_CLEAR  out  1  acknowledge/clear to receiver
TX_DATA  out  DATA_W  word presented to transmitter
TX_LOAD  out  1  start request to transmitter
TX_BUSY  in  1  transmitter shifting
FLUSH  in  1  synchronous FIFO clear (e.g. from button)
COUNT  out  $clog2(DEPTH)+1  current occupancy
EMPTY  out  1  COUNT==0
FULL  out  1  COUNT==DEPTH
OVERFLOW  out  1  sticky: a received word was dropped

Behaviour:
Reset:
- Async, RST_N low: RX_CLEAR=0, TX_LOAD=0, TX_DATA=0, COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0, pointers 0, both FSMs idle.
- Deassertion takes effect on the first clock edge; an RX/TX transfer in flight is abandoned with no replay.

Ingest FSM (I_IDLE, I_CLEAR):
- I_IDLE, RX_READY=1:
  - If !FULL and !FLUSH: write RX_DATA at wr_ptr and advance.
  - Else: set OVERFLOW (dropped when FULL; silently discarded when FLUSH).
  - Register RX_CLEAR<=1, go I_CLEAR.
- I_CLEAR: hold RX_CLEAR=1 until RX_READY samples 0, then RX_CLEAR<=0, go I_IDLE.
- Guarantees exactly one push per RX_READY pulse regardless of how long RX_READY stays high.
- Latency: RX_READY rises at edge n → COUNT and RX_CLEAR updated at n+1.

Drain FSM (D_IDLE, D_LOAD, D_BUSY):
- D_IDLE, !EMPTY and !TX_BUSY: TX_DATA<=mem[rd_ptr], pop, TX_LOAD<=1, go D_LOAD.
- D_LOAD: hold TX_LOAD and TX_DATA stable.
  - On TX_BUSY=1: TX_LOAD<=0, go D_BUSY.
  - If LOAD_TIMEOUT cycles elapse first: TX_LOAD<=0, go D_IDLE; the word is lost.
- D_BUSY: on TX_BUSY=0, go D_IDLE.
- Empty FIFO with idle TX: word at edge n → TX_LOAD high at n+2.
- TX_DATA holds its last value outside D_LOAD.

FIFO arithmetic:
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- COUNT: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
- FULL and EMPTY are derived from COUNT.
- Push decision uses the registered FULL: a push while FULL is dropped even if a pop occurs in the same cycle.
- Pop never occurs when EMPTY.

FLUSH:
- One cycle of FLUSH=1: pointers<=0, COUNT<=0, OVERFLOW<=0.
- FLUSH beats a simultaneous push and a simultaneous pop; the pop is cancelled and D_IDLE does not start that cycle.
- An in-progress drain (D_LOAD/D_BUSY) completes normally.
- The ingest handshake completes normally.

Decomposition:
- Package uart_echo_pkg: ingest and drain state encodings, default DEPTH/DATA_W, LOAD_TIMEOUT counter width.
- One sub-module, sync_fifo: storage array, pointers, COUNT, FULL/EMPTY, flush. Push/pop are qualified in the parent.
- The two FSMs and the timeout counter stay in uart_echo_fifo.

Test Plan:
1. Single word: RX_DATA=16'h0041, RX_READY pulse for 3 cycles, TX_BUSY idle → exactly one push; RX_CLEAR high until RX_READY low; TX_LOAD at n+2 with TX_DATA=0x0041; TX_BUSY model 5 cycles → COUNT returns 0, EMPTY=1.
2. Burst while busy: hold TX_BUSY=1, send 0x31,0x32,0x33 → COUNT=3; release TX_BUSY → TX_DATA sequence 0x31,0x32,0x33, one TX_LOAD per word.
3. Overflow: TX_BUSY stuck 1, send DEPTH+2 words → FULL=1, COUNT=16, OVERFLOW=1; after release, first 16 words emerge in order, last 2 absent.
4. Wrap-around: 40 words with a TX model that alternately stalls → output order equals input order across pointer wrap; COUNT never exceeds 16.
5. Flush and timeout: COUNT=5, assert FLUSH with simultaneous RX_READY → COUNT=0, OVERFLOW=0, no TX_LOAD afterwards. Separately, keep TX_BUSY=0 in D_LOAD → TX_LOAD drops after 1024 cycles and the next word is served.
6. Reset mid-operation: drop RST_N during D_LOAD with COUNT=4 → outputs at reset values asynchronously; after release no TX_LOAD until a new RX_READY.

Source files
------------

// File: rtl/uart_echo_pkg.sv
// Shared types and defaults for the UART echo buffer: FSM encodings,
// default widths and the width of the TX_LOAD timeout down-counter.
package uart_echo_pkg;

    localparam int DEF_DATA_W       = 16;
    localparam int DEF_DEPTH        = 16;
    localparam int DEF_LOAD_TIMEOUT = 1024;

    // Timeout counter width; LOAD_TIMEOUT must stay below 2**LOAD_TMO_W.
    localparam int LOAD_TMO_W = 16;

    typedef enum logic {
        I_IDLE,
        I_CLEAR
    } ingest_state_t;

    typedef enum logic [1:0] {
        D_IDLE,
        D_LOAD,
        D_BUSY
    } drain_state_t;

endpackage

// File: rtl/uart_echo_fifo_sync_fifo.sv
// Synchronous FIFO: storage, wrapping pointers, occupancy count and flush.
// Push/pop arrive already qualified by the parent; flush overrides both.
module sync_fifo
    import uart_echo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/uart_echo_fifo.sv
// Buffered UART echo: ingest FSM drains RX words into a FIFO, drain FSM
// replays them to the transmitter with a bounded wait on TX_BUSY.
//
// state   | meaning
// I_IDLE  | waiting for RX_READY; push (or drop) on its first sampled cycle
// I_CLEAR | RX_CLEAR held high until the receiver drops RX_READY
// D_IDLE  | waiting for a stored word and an idle transmitter
// D_LOAD  | TX_LOAD held with stable TX_DATA until TX_BUSY or timeout
// D_BUSY  | transmitter shifting; wait for TX_BUSY to fall
module uart_echo_fifo
    import uart_echo_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int LOAD_TIMEOUT = DEF_LOAD_TIMEOUT
) (
    input  logic                     CLK_100MHz,
    input  logic                     RST_N,
    input  logic [DATA_W-1:0]        RX_DATA,
    input  logic                     RX_READY,
    output logic                     RX_CLEAR,
    output logic [DATA_W-1:0]        TX_DATA,
    output logic                     TX_LOAD,
    input  logic                     TX_BUSY,
    input  logic                     FLUSH,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic                     OVERFLOW
);
    ingest_state_t         i_state_q, i_state_d;
    drain_state_t          d_state_q, d_state_d;
    logic                  rx_clear_q, rx_clear_d;
    logic                  tx_load_q, tx_load_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_W-1:0]     tx_data_q, tx_data_d;
    logic [LOAD_TMO_W-1:0] tmo_q, tmo_d;

    logic                  push, pop;
    logic [DATA_W-1:0]     fifo_rd_data;
    logic                  fifo_empty, fifo_full;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (CLK_100MHz),
        .rst_n     (RST_N),
        .push      (push),
        .push_data (RX_DATA),
        .pop       (pop),
        .flush     (FLUSH),
        .rd_data   (fifo_rd_data),
        .count     (COUNT),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        i_state_d  = i_state_q;
        rx_clear_d = rx_clear_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        case (i_state_q)
            I_IDLE: if (RX_READY) begin
                if (!fifo_full && !FLUSH) push = 1'b1;
                else if (fifo_full)       overflow_d = 1'b1;
                rx_clear_d = 1'b1;
                i_state_d  = I_CLEAR;
            end
            I_CLEAR: if (!RX_READY) begin
                rx_clear_d = 1'b0;
                i_state_d  = I_IDLE;
            end
            default: i_state_d = I_IDLE;
        endcase
        // A flush wipes the sticky flag even if this cycle's word was dropped.
        if (FLUSH) overflow_d = 1'b0;
    end

    always_comb begin
        d_state_d = d_state_q;
        tx_load_d = tx_load_q;
        tx_data_d = tx_data_q;
        tmo_d     = tmo_q;
        pop       = 1'b0;
        case (d_state_q)
            D_IDLE: if (!fifo_empty && !TX_BUSY && !FLUSH) begin
                tx_data_d = fifo_rd_data;
                pop       = 1'b1;
                tx_load_d = 1'b1;
                tmo_d     = LOAD_TMO_W'(LOAD_TIMEOUT - 1);
                d_state_d = D_LOAD;
            end
            D_LOAD: begin
                if (TX_BUSY) begin
                    tx_load_d = 1'b0;
                    d_state_d = D_BUSY;
                end else if (tmo_q == '0) begin
                    tx_load_d = 1'b0;
                    d_state_d = D_IDLE;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            D_BUSY: if (!TX_BUSY) d_state_d = D_IDLE;
            default: d_state_d = D_IDLE;
        endcase
    end

    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N) begin
            i_state_q  <= I_IDLE;
            d_state_q  <= D_IDLE;
            rx_clear_q <= 1'b0;
            tx_load_q  <= 1'b0;
            overflow_q <= 1'b0;
            tx_data_q  <= '0;
            tmo_q      <= '0;
        end else begin
            i_state_q  <= i_state_d;
            d_state_q  <= d_state_d;
            rx_clear_q <= rx_clear_d;
            tx_load_q  <= tx_load_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
            tmo_q      <= tmo_d;
        end
    end

    assign RX_CLEAR = rx_clear_q;
    assign TX_LOAD  = tx_load_q;
    assign TX_DATA  = tx_data_q;
    assign OVERFLOW = overflow_q;
    assign EMPTY    = fifo_empty;
    assign FULL     = fifo_full;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Scoreboard bench for uart_echo_fifo: accepted words are queued as they are
// sent, a monitor pops and compares on every rising TX_LOAD.
module tb_uart_echo_fifo;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int TMO    = 1024;

    logic              clk = 1'b0;
    logic              RST_N;
    logic [DATA_W-1:0] RX_DATA;
    logic              RX_READY;
    logic              RX_CLEAR;
    logic [DATA_W-1:0] TX_DATA;
    logic              TX_LOAD;
    logic              TX_BUSY;
    logic              FLUSH;
    logic [4:0]        COUNT;
    logic              EMPTY, FULL, OVERFLOW;

    uart_echo_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LOAD_TIMEOUT(TMO)) dut (
        .CLK_100MHz (clk),
        .RST_N      (RST_N),
        .RX_DATA    (RX_DATA),
        .RX_READY   (RX_READY),
        .RX_CLEAR   (RX_CLEAR),
        .TX_DATA    (TX_DATA),
        .TX_LOAD    (TX_LOAD),
        .TX_BUSY    (TX_BUSY),
        .FLUSH      (FLUSH),
        .COUNT      (COUNT),
        .EMPTY      (EMPTY),
        .FULL       (FULL),
        .OVERFLOW   (OVERFLOW)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [DATA_W-1:0] exp_q[$];
    int unsigned sent_cnt = 0;
    int unsigned load_cnt = 0;
    int unsigned cyc = 0;
    int unsigned rise_cyc = 0;
    int unsigned high_len = 0;
    int unsigned max_count = 0;
    logic        prev_load = 1'b0;
    logic [DATA_W-1:0] mon_exp;

    bit tx_force = 0;
    bit tx_mute  = 0;
    bit tx_rand  = 0;
    int tx_len   = 5;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Transmitter model: accepts a load (optionally after a stall), then busy.
    initial begin
        int n;
        TX_BUSY = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_force) TX_BUSY = 1'b1;
            else if (TX_LOAD && !tx_mute && RST_N) begin
                if (tx_rand) repeat ($urandom_range(0, 3)) @(negedge clk);
                TX_BUSY = 1'b1;
                n = tx_rand ? int'($urandom_range(1, 6)) : tx_len;
                repeat (n) @(negedge clk);
                TX_BUSY = 1'b0;
            end else TX_BUSY = 1'b0;
        end
    end

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (int'(COUNT) > max_count) max_count = COUNT;
            if (TX_LOAD && !prev_load) begin
                load_cnt++;
                rise_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_load got %0h expected none", TX_DATA);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("tx_data", TX_DATA, mon_exp);
                end
            end
            if (!TX_LOAD && prev_load) high_len = cyc - rise_cyc;
            prev_load = TX_LOAD;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send_word(input logic [DATA_W-1:0] d, input bit accept, input int hold);
        @(negedge clk);
        RX_DATA  = d;
        RX_READY = 1'b1;
        if (accept) begin
            exp_q.push_back(d);
            sent_cnt++;
        end
        repeat (hold) @(negedge clk);
        chk("rx_clear_ack", RX_CLEAR, 1);
        RX_READY = 1'b0;
        @(negedge clk);
        chk("rx_clear_release", RX_CLEAR, 0);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || TX_LOAD || TX_BUSY || !EMPTY) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drain_done"}, (n < 3000), 1);
        chk({nm, "_count_zero"}, COUNT, 0);
    endtask

    initial begin
        int unsigned lb;
        int n;
        RST_N = 1'b0; RX_DATA = '0; RX_READY = 1'b0; FLUSH = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rx_clear", RX_CLEAR, 0);
        chk("rst_tx_load", TX_LOAD, 0);
        chk("rst_tx_data", TX_DATA, 0);
        chk("rst_count", COUNT, 0);
        chk("rst_empty", EMPTY, 1);
        chk("rst_full", FULL, 0);
        chk("rst_overflow", OVERFLOW, 0);
        RST_N = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single word, RX_READY held 3 cycles
        @(negedge clk);
        RX_DATA = 16'h0041; RX_READY = 1'b1; exp_q.push_back(16'h0041); sent_cnt++;
        @(negedge clk);
        chk("t1_count_n1", COUNT, 1);
        chk("t1_rx_clear_n1", RX_CLEAR, 1);
        chk("t1_load_not_yet", TX_LOAD, 0);
        @(negedge clk);
        chk("t1_load_n2", TX_LOAD, 1);
        chk("t1_data_n2", TX_DATA, 16'h0041);
        chk("t1_rx_clear_hold", RX_CLEAR, 1);
        @(negedge clk);
        RX_READY = 1'b0;
        @(negedge clk);
        chk("t1_rx_clear_drop", RX_CLEAR, 0);
        drain("t1");
        chk("t1_empty", EMPTY, 1);
        chk("t1_one_load", load_cnt, 1);

        // 2: burst while transmitter busy
        tx_force = 1;
        repeat (2) @(negedge clk);
        send_word(16'h0031, 1, 1);
        send_word(16'h0032, 1, 2);
        send_word(16'h0033, 1, 1);
        chk("t2_count3", COUNT, 3);
        lb = load_cnt;
        tx_force = 0;
        drain("t2");
        chk("t2_loads", load_cnt, lb + 3);

        // 3: overflow with transmitter stuck
        tx_force = 1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) send_word(16'(16'h0100 + i), 1, 1);
        chk("t3_full_at_depth", FULL, 1);
        chk("t3_no_ovf_yet", OVERFLOW, 0);
        send_word(16'hdead, 0, 1);
        send_word(16'hbeef, 0, 1);
        chk("t3_full", FULL, 1);
        chk("t3_count16", COUNT, DEPTH);
        chk("t3_overflow", OVERFLOW, 1);
        tx_force = 0;
        drain("t3");
        chk("t3_ovf_sticky", OVERFLOW, 1);

        // 5a: flush with simultaneous RX_READY
        tx_force = 1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) send_word(16'($urandom), 0, 1);
        chk("t5_count5", COUNT, 5);
        @(negedge clk);
        RX_DATA = 16'h5a5a; RX_READY = 1'b1; FLUSH = 1'b1;
        @(negedge clk);
        FLUSH = 1'b0;
        chk("t5_flush_count", COUNT, 0);
        chk("t5_flush_ovf", OVERFLOW, 0);
        chk("t5_flush_empty", EMPTY, 1);
        chk("t5_flush_rx_clear", RX_CLEAR, 1);
        RX_READY = 1'b0;
        @(negedge clk);
        chk("t5_flush_rx_release", RX_CLEAR, 0);
        chk("t5_flush_count_after", COUNT, 0);
        lb = load_cnt;
        tx_force = 0;
        repeat (30) @(negedge clk);
        chk("t5_no_load_after_flush", load_cnt, lb);

        // 4: wrap-around with a stalling transmitter
        tx_rand = 1;
        max_count = 0;
        for (int i = 0; i < 40; i++) begin
            n = 0;
            while ((sent_cnt - load_cnt) >= DEPTH && n < 500) begin
                @(negedge clk);
                n++;
            end
            send_word(16'($urandom), 1, int'($urandom_range(1, 3)));
        end
        drain("t4");
        chk("t4_count_bound", (max_count <= DEPTH), 1);
        tx_rand = 0;

        // 5b: load timeout, next word still served
        tx_mute = 1;
        lb = load_cnt;
        send_word(16'h0a0a, 1, 1);
        send_word(16'h0b0b, 1, 1);
        n = 0;
        while (load_cnt < lb + 2 && n < 1500) begin
            @(negedge clk);
            n++;
        end
        chk("t5_second_served", load_cnt, lb + 2);
        chk("t5_timeout_len", high_len, TMO);
        tx_mute = 0;
        drain("t5b");

        // 6: reset during D_LOAD with four words queued
        tx_mute = 1;
        for (int i = 0; i < 5; i++) send_word(16'(16'h0600 + i), 1, 1);
        chk("t6_count4", COUNT, 4);
        chk("t6_in_load", TX_LOAD, 1);
        @(negedge clk);
        #2;
        RST_N = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_rst_load", TX_LOAD, 0);
        chk("t6_rst_data", TX_DATA, 0);
        chk("t6_rst_count", COUNT, 0);
        chk("t6_rst_empty", EMPTY, 1);
        chk("t6_rst_rx_clear", RX_CLEAR, 0);
        chk("t6_rst_ovf", OVERFLOW, 0);
        repeat (2) @(negedge clk);
        #2;
        RST_N = 1'b1;
        tx_mute = 0;
        lb = load_cnt;
        repeat (40) @(negedge clk);
        chk("t6_no_replay", load_cnt, lb);
        send_word(16'h0777, 1, 1);
        drain("t6");
        chk("t6_new_word_loaded", load_cnt, lb + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
